// File: rtl/sram_bus_master_if.sv
// Command / write-stream / read-stream bundle between the CPU memory stage
// and the SRAM bus master. The master modport is the bus-master side.
interface sram_bus_master_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADX_LENGTH = 11,
    parameter int LEN_WIDTH  = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADX_LENGTH-1:0] cmd_adx;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  done;

    modport master (
        input  cmd_valid, cmd_write, cmd_adx, cmd_len, wr_data, wr_valid,
        output cmd_ready, wr_ready, rd_data, rd_valid, done
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_adx, cmd_len, wr_data, wr_valid,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done
    );
endinterface

// File: rtl/sram_bus_master.sv
// SRAM bus master: runs single or burst (1..16 word) read/write commands
// against a 2K x 16 asynchronous-read SRAM with an active-low write enable
// and a shared tri-state data bus.
module sram_bus_master #(
    parameter int DATA_WIDTH = 16,
    parameter int ADX_LENGTH = 11,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_bus_master_if.master     bus,
    output logic [ADX_LENGTH-1:0] sram_adx,
    output logic                  sram_WrEn,
    inout  wire  [DATA_WIDTH-1:0] sram_data
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                r_state,    w_state_nxt;
    logic [ADX_LENGTH-1:0] r_ptr,      w_ptr_nxt;
    logic [ADX_LENGTH-1:0] r_adx,      w_adx_nxt;
    logic [LEN_WIDTH-1:0]  r_count,    w_count_nxt;
    logic                  r_wren_n,   w_wren_n_nxt;
    logic [DATA_WIDTH-1:0] r_wdata,    w_wdata_nxt;
    logic [DATA_WIDTH-1:0] r_rd_data,  w_rd_data_nxt;
    logic                  r_rd_valid, w_rd_valid_nxt;

    // The bus driver enable is the write-enable flop itself, so the master
    // only drives while the SRAM is in write mode and never overlaps it.
    assign sram_data = r_wren_n ? {DATA_WIDTH{1'bz}} : r_wdata;
    assign sram_adx  = r_adx;
    assign sram_WrEn = r_wren_n;

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.wr_ready  = (r_state == WRITE);
    assign bus.done      = (r_state == DONE);
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Datapath registers; reset forces write-enable high so a burst cut by
    // reset commits nothing past the reset edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr      <= '0;
            r_adx      <= '0;
            r_count    <= '0;
            r_wren_n   <= 1'b1;
            r_wdata    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_adx      <= w_adx_nxt;
            r_count    <= w_count_nxt;
            r_wren_n   <= w_wren_n_nxt;
            r_wdata    <= w_wdata_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_adx_nxt      = r_adx;
        w_count_nxt    = r_count;
        w_wren_n_nxt   = r_wren_n;
        w_wdata_nxt    = r_wdata;
        w_rd_data_nxt  = r_rd_data;
        w_rd_valid_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_ptr_nxt   = bus.cmd_adx;
                    w_count_nxt = bus.cmd_len;
                    if (bus.cmd_write) begin
                        w_state_nxt = WRITE;
                    end else begin
                        // Present the first read address now so the SRAM
                        // output is ready at the first READ edge.
                        w_state_nxt = READ;
                        w_adx_nxt   = bus.cmd_adx;
                    end
                end
            end

            WRITE: begin
                if (bus.wr_valid) begin
                    w_adx_nxt    = r_ptr;
                    w_wdata_nxt  = bus.wr_data;
                    w_wren_n_nxt = 1'b0;
                    w_ptr_nxt    = r_ptr + ADX_LENGTH'(1);
                    w_count_nxt  = r_count - LEN_WIDTH'(1);
                    if (r_count == '0) w_state_nxt = DONE;
                end else begin
                    w_wren_n_nxt = 1'b1;
                end
            end

            READ: begin
                // sram_adx tracks ptr, so each edge captures the word at ptr.
                w_rd_data_nxt  = sram_data;
                w_rd_valid_nxt = 1'b1;
                w_ptr_nxt      = r_ptr + ADX_LENGTH'(1);
                w_adx_nxt      = r_ptr + ADX_LENGTH'(1);
                w_count_nxt    = r_count - LEN_WIDTH'(1);
                if (r_count == '0) w_state_nxt = DONE;
            end

            DONE: begin
                w_wren_n_nxt = 1'b1;
                w_state_nxt  = IDLE;
            end

            default: begin
                w_state_nxt  = IDLE;
                w_wren_n_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_bus_master.sv
// Directed bench for sram_bus_master with a behavioural 2K x 16 SRAM.
module tb_sram_bus_master;

    logic        clk;
    logic        rst;
    logic [10:0] sram_adx;
    logic        sram_WrEn;
    wire  [15:0] sram_data;

    logic [15:0] mem [0:2047] = '{default: 16'h0000};

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int acc_cyc;

    logic [10:0] wa [$];
    logic [15:0] wd [$];
    logic [15:0] rd_q [$];
    int          rd_c [$];
    int          done_c [$];

    sram_bus_master_if #(.DATA_WIDTH(16), .ADX_LENGTH(11), .LEN_WIDTH(4)) bus ();

    sram_bus_master #(.DATA_WIDTH(16), .ADX_LENGTH(11), .LEN_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sram_adx  (sram_adx),
        .sram_WrEn (sram_WrEn),
        .sram_data (sram_data)
    );

    // Asynchronous-read SRAM: drives the bus whenever not being written
    assign sram_data = sram_WrEn ? mem[sram_adx] : 16'hzzzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM write port plus a log of every committed word
    always @(posedge clk) begin
        if (!sram_WrEn) begin
            mem[sram_adx] = sram_data;
            wa.push_back(sram_adx);
            wd.push_back(sram_data);
        end
    end

    // Read-stream and done-pulse log
    always @(negedge clk) begin
        if (rst && bus.rd_valid) begin
            rd_q.push_back(bus.rd_data);
            rd_c.push_back(cyc);
        end
        if (rst && bus.done) done_c.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clear_logs();
        wa.delete(); wd.delete(); rd_q.delete(); rd_c.delete(); done_c.delete();
    endtask

    task automatic send_cmd(input logic w, input logic [10:0] a, input logic [3:0] l);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_adx   = a;
        bus.cmd_len   = l;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic push_word(input logic [15:0] d);
        int n;
        n = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        @(negedge clk);
        while (!bus.wr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("wr_ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    // Word i of the burst is base + i*step; two bubble cycles precede word gap_at
    task automatic do_write(input logic [10:0] a, input logic [3:0] l,
                            input logic [15:0] base, input logic [15:0] step,
                            input int gap_at);
        send_cmd(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            if (i == gap_at) begin
                bus.wr_valid = 1'b0;
                repeat (2) begin
                    @(posedge clk); #1;
                    check("bubble_wren", 32'(sram_WrEn), 1);
                end
            end
            push_word(base + 16'(i) * step);
        end
        bus.wr_valid = 1'b0;
        wait_done();
    endtask

    task automatic do_read(input logic [10:0] a, input logic [3:0] l);
        send_cmd(1'b0, a, l);
        wait_done();
    endtask

    initial begin
        int bad;
        int busy_ready;

        rst = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_adx = '0; bus.cmd_len = '0;
        bus.wr_valid  = 1'b0; bus.wr_data   = '0;

        // Reset with random inputs
        repeat (2) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_write = 1'($urandom_range(0, 1));
            bus.cmd_adx   = 11'($urandom_range(0, 2047));
            bus.cmd_len   = 4'($urandom_range(0, 15));
            bus.wr_valid  = 1'($urandom_range(0, 1));
            bus.wr_data   = 16'($urandom_range(0, 65535));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rst_wren",     32'(sram_WrEn),     1);
        check("rst_adx",      32'(sram_adx),      0);
        check("rst_cmd_rdy",  32'(bus.cmd_ready), 1);
        check("rst_rd_valid", 32'(bus.rd_valid),  0);
        check("rst_rd_data",  32'(bus.rd_data),   0);
        check("rst_done",     32'(bus.done),      0);
        bus.cmd_valid = 1'b0; bus.wr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        clear_logs();

        // Single write then read back
        do_write(11'h010, 4'd0, 16'h1234, 16'h0, -1);
        check("sw_nwrites", wa.size(), 1);
        check("sw_adx",     32'(wa[0]), 32'h010);
        check("sw_data",    32'(wd[0]), 32'h1234);
        check("sw_ndone",   done_c.size(), 1);
        clear_logs();
        do_read(11'h010, 4'd0);
        check("sr_nreads",  rd_q.size(), 1);
        check("sr_data",    32'(rd_q[0]), 32'h1234);
        // strobe first seen after edge accept+1, consumed at edge accept+2
        check("sr_latency", rd_c[0] - acc_cyc, 1);
        check("sr_done_on_last", done_c[0], rd_c[0]);
        check("sr_nowrite", wa.size(), 0);
        clear_logs();

        // Wrapping burst write with a two-cycle bubble, then read-back
        do_write(11'h7FE, 4'd3, 16'hA000, 16'h1, 2);
        check("wrap_nwrites", wa.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_adx%0d", i),  32'(wa[i]), 32'(11'(11'h7FE + 11'(i))));
            check($sformatf("wrap_data%0d", i), 32'(wd[i]), 32'(16'hA000 + 16'(i)));
        end
        clear_logs();
        do_read(11'h7FE, 4'd3);
        check("wrap_nreads", rd_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("wrap_rd%0d", i), 32'(rd_q[i]), 32'(16'hA000 + 16'(i)));
        clear_logs();

        // Full 16-word burst: write k*3 at 0x100.., then read with wr_valid held high
        do_write(11'h100, 4'd15, 16'h0, 16'h3, -1);
        check("full_nwrites", wa.size(), 16);
        clear_logs();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'hFFFF;
        do_read(11'h100, 4'd15);
        bus.wr_valid = 1'b0;
        check("full_nreads", rd_q.size(), 16);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full_rd%0d", i), 32'(rd_q[i]), 32'(i * 3));
            if (i > 0 && rd_c[i] != rd_c[i-1] + 1) bad++;
        end
        check("full_no_gaps",   bad, 0);
        check("full_latency",   rd_c[0] - acc_cyc, 1);
        check("full_done_last", done_c[0], rd_c[15]);
        check("full_wr_ignored", wa.size(), 0);
        clear_logs();

        // Reset after two of four write words
        send_cmd(1'b1, 11'h200, 4'd3);
        push_word(16'hB000);
        push_word(16'hB001);
        rst = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'hB002;
        @(posedge clk); #1;
        check("mid_rst_wren", 32'(sram_WrEn), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.wr_valid = 1'b0;
        @(negedge clk);
        check("mid_cmd_rdy", 32'(bus.cmd_ready), 1);
        check("mid_nwrites", wa.size(), 2);
        check("mid_m200", 32'(mem[11'h200]), 32'hB000);
        check("mid_m201", 32'(mem[11'h201]), 32'hB001);
        check("mid_m202", 32'(mem[11'h202]), 32'h0000);
        check("mid_m203", 32'(mem[11'h203]), 32'h0000);
        check("mid_ndone", done_c.size(), 0);
        @(posedge clk); #1;
        clear_logs();

        // cmd_valid held through a write burst, read queued behind it
        busy_ready = 0;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_adx = 11'h300; bus.cmd_len = 4'd1;
        @(posedge clk); #1;
        bus.cmd_write = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 16'hC000 + 16'(i);
            @(negedge clk);
            if (bus.cmd_ready) busy_ready++;
            @(posedge clk); #1;
        end
        bus.wr_valid = 1'b0;
        @(negedge clk);
        if (bus.cmd_ready) busy_ready++;
        check("ct_done_pulse", 32'(bus.done), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("ct_idle_rdy", 32'(bus.cmd_ready), 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        acc_cyc = cyc;
        wait_done();
        check("ct_busy_rdy",  busy_ready, 0);
        check("ct_nwrites",   wa.size(), 2);
        check("ct_wadx1",     32'(wa[1]), 32'h301);
        check("ct_nreads",    rd_q.size(), 2);
        check("ct_rd0",       32'(rd_q[0]), 32'hC000);
        check("ct_rd1",       32'(rd_q[1]), 32'hC001);
        check("ct_rd_latency", rd_c[0] - acc_cyc, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
